// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and a parity helper used by both link ends.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // 1 when the vector holds an odd number of ones.
  function automatic logic odd_ones(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus one extra flop
// for falling-edge detection; all flops reset to the idle-high level.
module uart_rx_sync (
  input  logic div_clk,
  input  logic rst_n,
  input  logic rx_serial,
  output logic rx_sync,
  output logic fall_edge
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx_serial;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_sync   = sync_q;
  assign fall_edge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver (8N1 by default) with a valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 div_clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic rx_sync, fall_edge;

  uart_rx_sync u_sync (
    .div_clk   (div_clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_sync   (rx_sync),
    .fall_edge (fall_edge)
  );

  uart_rx_state_e       state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 perr_q, perr_d;
  logic [TW-1:0]        tick_next;

  assign tick_next = (tick_q == TICK_END) ? '0 : tick_q + TICK_ONE;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_next;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (fall_edge) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_q == TICK_MID) begin
          tick_d = '0;
          bit_d  = '0;
          // A line already back high at mid-start is noise, not a frame.
          if (!rx_sync) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_q == TICK_END) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_q == TICK_END) begin
          perr_d  = odd_ones(9'(shift_q)) ^ rx_sync;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_q == TICK_END) begin
          state_d = IDLE;
          // A bad stop bit leaves the previously delivered byte untouched.
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            oerr_d  = valid_q & ~rx_ready;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      perr_q  <= perr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != IDLE);
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign parity_err  = perr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames plus random
// frames, checked every cycle against a frame-level timing model.
module tb_uart_rx_deserializer;

  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Line fall to rx_valid: start + data (+ parity) bits, half a stop bit, 3 cycles.
  localparam int LAT = (1 + DB + (PAR_EN ? 1 : 0)) * OS + OS / 2 + 3;

  logic          div_clk   = 1'b0;
  logic          rst_n     = 1'b1;
  logic          rx_serial = 1'b1;
  logic          rx_ready  = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_busy, frame_err, overrun_err, parity_err;

  uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .div_clk     (div_clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 div_clk = ~div_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge div_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            stop_cyc;
    int            par_cyc;
    logic [DB-1:0] data;
    bit            stop_ok;
    bit            par_bad;
  } frame_t;

  frame_t        pend[$];
  logic          m_valid = 1'b0;
  logic [DB-1:0] m_data  = '0;
  logic          m_ferr  = 1'b0;
  logic          m_oerr  = 1'b0;
  logic          m_perr  = 1'b0;
  int            busy_lo = 0;
  int            busy_hi = -1;

  // Frame-level model: each frame's outcome lands on a precomputed cycle.
  always @(posedge div_clk or negedge rst_n) begin
    logic          nv, fe, oe, pe;
    logic [DB-1:0] nd;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ferr  <= 1'b0;
      m_oerr  <= 1'b0;
      m_perr  <= 1'b0;
      pend.delete();
    end else begin
      nv = m_valid && !rx_ready;
      nd = m_data;
      fe = 1'b0;
      oe = 1'b0;
      pe = 1'b0;
      if (pend.size() > 0 && pend[0].par_cyc == cyc + 1) pe = pend[0].par_bad;
      if (pend.size() > 0 && pend[0].stop_cyc == cyc + 1) begin
        if (pend[0].stop_ok) begin
          oe = m_valid && !rx_ready;
          nv = 1'b1;
          nd = pend[0].data;
        end else begin
          fe = 1'b1;
        end
        void'(pend.pop_front());
      end
      m_valid <= nv;
      m_data  <= nd;
      m_ferr  <= fe;
      m_oerr  <= oe;
      m_perr  <= pe;
    end
  end

  int            rise_cnt = 0, rise_cyc = 0, valid_cycles = 0;
  int            ferr_cnt = 0, oerr_cnt = 0, perr_cnt = 0;
  logic [DB-1:0] rise_data = '0;
  logic          prev_v = 1'b0;

  // Per-cycle compare against the model, plus event counters for directed checks.
  always @(negedge div_clk) begin
    if (cyc > 0) begin
      chk("rx_valid", 32'(rx_valid), 32'(m_valid));
      chk("rx_data", 32'(rx_data), 32'(m_data));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun_err", 32'(overrun_err), 32'(m_oerr));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
      chk("rx_busy", 32'(rx_busy), 32'(rst_n && cyc >= busy_lo && cyc <= busy_hi));
    end
    if (rx_valid && !prev_v) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = rx_data;
    end
    prev_v = rx_valid;
    if (rx_valid) valid_cycles++;
    if (frame_err) ferr_cnt++;
    if (overrun_err) oerr_cnt++;
    if (parity_err) perr_cnt++;
  end

  int ready_mode = 1;  // 0: never ready, 1: always ready, 2: random
  initial begin
    forever begin
      @(posedge div_clk);
      #1;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit stop, input bit par_bit, output int k);
    frame_t f;
    tick();
    k          = cyc;
    f.stop_cyc = k + LAT;
    f.par_cyc  = k + LAT - OS;
    f.data     = d;
    f.stop_ok  = stop;
    f.par_bad  = PAR_EN && (par_bit != ^d);
    pend.push_back(f);
    busy_lo = k + 3;
    busy_hi = k + LAT - 1;
    rx_serial = 1'b0;
    repeat (OS) tick();
    for (int i = 0; i < DB; i++) begin
      rx_serial = d[i];
      repeat (OS) tick();
    end
    if (PAR_EN) begin
      rx_serial = par_bit;
      repeat (OS) tick();
    end
    rx_serial = stop;
    repeat (OS) tick();
    rx_serial = 1'b1;
  endtask

  int k, r0, f0, o0, p0, v0;

  initial begin
    #2 rst_n = 1'b0;
    repeat (4) tick();
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_data", 32'(rx_data), 32'h0);
    chk("reset_busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();

    // 0xA5 with the consumer always ready.
    ready_mode = 1;
    r0 = rise_cnt; v0 = valid_cycles; f0 = ferr_cnt; o0 = oerr_cnt; p0 = perr_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5, k);
    repeat (3) tick();
    chk("a5_rises", 32'(rise_cnt - r0), 32'd1);
    chk("a5_latency", 32'(rise_cyc - k), PAR_EN ? 32'd171 : 32'd155);
    chk("a5_data", 32'(rise_data), 32'hA5);
    chk("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    chk("a5_no_errors", 32'(ferr_cnt - f0 + oerr_cnt - o0 + perr_cnt - p0), 32'd0);

    // Short low glitch: a false start.
    tick();
    busy_lo = cyc + 3;
    busy_hi = cyc + 3 + OS / 2 - 1;
    r0 = rise_cnt;
    rx_serial = 1'b0;
    repeat (4) tick();
    rx_serial = 1'b1;
    repeat (20) tick();
    chk("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
    chk("glitch_idle", 32'(rx_busy), 32'd0);

    // Bad stop bit, then a clean frame.
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C, k);
    repeat (4) tick();
    chk("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_no_valid", 32'(rise_cnt - r0), 32'd0);
    send_frame(8'h55, 1'b1, ^8'h55, k);
    repeat (3) tick();
    chk("after_ferr_data", 32'(rise_data), 32'h55);

    // Two bytes with no consumer: overrun on the second.
    ready_mode = 0;
    repeat (2) tick();
    o0 = oerr_cnt;
    send_frame(8'h11, 1'b1, ^8'h11, k);
    send_frame(8'h22, 1'b1, ^8'h22, k);
    repeat (3) tick();
    chk("ovr_pulses", 32'(oerr_cnt - o0), 32'd1);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h22);

    // Reset in the middle of data bit 4, then 0x81.
    tick();
    busy_lo = cyc + 3;
    busy_hi = cyc + LAT - 1;
    rx_serial = 1'b0;
    repeat (OS) tick();
    for (int i = 0; i < 4; i++) begin
      rx_serial = i[0];
      repeat (OS) tick();
    end
    rx_serial = 1'b1;
    repeat (OS / 2) tick();
    rst_n = 1'b0;
    busy_hi = -1;
    #1;
    chk("midrst_valid", 32'(rx_valid), 32'h0);
    chk("midrst_data", 32'(rx_data), 32'h0);
    chk("midrst_busy", 32'(rx_busy), 32'h0);
    repeat (4) tick();
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (5) tick();
    send_frame(8'h81, 1'b1, ^8'h81, k);
    repeat (3) tick();
    chk("post_rst_data", 32'(rise_data), 32'h81);
    chk("post_rst_latency", 32'(rise_cyc - k), PAR_EN ? 32'd171 : 32'd155);

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0, k);
    repeat (3) tick();
    chk("par_pulse", 32'(perr_cnt - p0), 32'd1);
    chk("par_data", 32'(rise_data), 32'h07);
`endif

    // Random traffic with a random consumer.
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      logic [DB-1:0] d;
      bit            st, pb;
      d  = DB'($urandom);
      st = ($urandom_range(0, 7) != 0);
      pb = ($urandom_range(0, 7) != 0) ? ^d : ~(^d);
      send_frame(d, st, pb, k);
      repeat (st ? $urandom_range(0, 12) : $urandom_range(2, 12)) tick();
    end
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
